// File: rtl/cacheline_mem_adapter_pkg.sv
// Shared types and constants for the cacheline <-> burst-memory adapter.
// The constants describe the 256-bit line / 4 x 64-bit beat geometry.
package cacheline_adapter_types;

    localparam int CLA_OFFSET_BITS = 5;  // byte offset within a 32-byte line
    localparam int CLA_BEAT_IDX_W  = 2;  // log2(beats per line)

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_RESP,
        WR_BURST
    } cla_state_t;

endpackage

// File: rtl/cacheline_mem_adapter_line_beat_buffer.sv
// Line-wide register addressable per beat: beats are deserialized in on reads
// and serialized out on writes, so both directions share one storage array.
module line_beat_buffer #(
    parameter int LINE_W    = 256,
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int IDX_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] line_in,
    input  logic              beat_we,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [LINE_W-1:0] line_out,
    output logic [BEAT_W-1:0] beat_out
);

    logic [BURST_LEN-1:0][BEAT_W-1:0] beats_q;

    for (genvar b = 0; b < BURST_LEN; b++) begin : g_beat
        always_ff @(posedge clk) begin
            if (rst)
                beats_q[b] <= '0;
            else if (load)
                beats_q[b] <= line_in[b*BEAT_W +: BEAT_W];
            else if (beat_we && beat_idx == IDX_W'(b))
                beats_q[b] <= beat_in;
        end
    end

    assign line_out = beats_q;
    assign beat_out = beats_q[beat_idx];

endmodule

// File: rtl/cacheline_mem_adapter.sv
// Cache-side line responder that turns each 256-bit line access into a
// 4-beat burst on the memory port. Optional counters: CACHELINE_ADAPTER_PERF_EN.
module cacheline_mem_adapter
    import cacheline_adapter_types::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ufp_addr,
    input  logic              ufp_read,
    input  logic              ufp_write,
    input  logic [LINE_W-1:0] ufp_wdata,
    output logic              ufp_ready,
    output logic [ADDR_W-1:0] ufp_raddr,
    output logic [LINE_W-1:0] ufp_rdata,
    output logic              ufp_rvalid,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    output logic [31:0]       perf_rd_lines,
    output logic [31:0]       perf_wr_lines,
    output logic [31:0]       perf_stall_cycles
`endif
);

    // Line geometry is tied to the package constants (LINE_W/BURST_LEN defaults).
    localparam int OFF_W = CLA_OFFSET_BITS;
    localparam int IDX_W = CLA_BEAT_IDX_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_LEN - 1);

    cla_state_t        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cnt_inc, cnt_clr, beat_we, load, accept;
    logic [LINE_W-1:0] line_out;
    logic [BEAT_W-1:0] beat_out;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^ufp_addr[OFF_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            if (accept)
                addr_q <= {ufp_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            if (cnt_inc)
                cnt_q <= cnt_q + 1'b1;  // wraps to 0 after the last beat
            else if (cnt_clr)
                cnt_q <= '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        beat_we    = 1'b0;
        load       = 1'b0;
        ufp_ready  = 1'b0;
        ufp_rvalid = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        unique case (state_q)
            IDLE: begin
                ufp_ready = !rst;
                if (ufp_write) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    state_d = WR_BURST;
                end else if (ufp_read) begin
                    accept  = 1'b1;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    cnt_clr = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // beats tagged for another line are dropped
                if (bmem_rvalid && bmem_raddr == addr_q) begin
                    beat_we = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                ufp_rvalid = 1'b1;
                state_d    = IDLE;
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                if (bmem_ready) begin
                    cnt_inc = 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    line_beat_buffer #(
        .LINE_W    (LINE_W),
        .BEAT_W    (BEAT_W),
        .BURST_LEN (BURST_LEN),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .line_in  (ufp_wdata),
        .beat_we  (beat_we),
        .beat_idx (cnt_q),
        .beat_in  (bmem_rdata),
        .line_out (line_out),
        .beat_out (beat_out)
    );

    assign ufp_raddr  = addr_q;
    assign ufp_rdata  = line_out;
    assign bmem_addr  = addr_q;
    assign bmem_wdata = beat_out;

`ifdef CACHELINE_ADAPTER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_lines     <= '0;
            perf_wr_lines     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (ufp_rvalid && perf_rd_lines != '1)
                perf_rd_lines <= perf_rd_lines + 1'b1;
            if (state_q == WR_BURST && bmem_ready && cnt_q == LAST_BEAT && perf_wr_lines != '1)
                perf_wr_lines <= perf_wr_lines + 1'b1;
            if ((bmem_read || bmem_write) && !bmem_ready && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
        end
    end
`endif

    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(state_q == IDLE && ufp_read && ufp_write));

    a_mismatch_dropped: assert property (@(posedge clk) disable iff (rst)
        (state_q == RD_WAIT && bmem_rvalid && bmem_raddr != addr_q) |=> (cnt_q == $past(cnt_q)));

endmodule

// File: tb/tb_cacheline_mem_adapter.sv
// Directed bench for cacheline_mem_adapter: reads, writes, stalls, stray beats,
// mid-burst reset, and the optional perf counters.
module tb_cacheline_mem_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  ufp_addr = '0;
    logic         ufp_read = 1'b0, ufp_write = 1'b0;
    logic [255:0] ufp_wdata = '0;
    logic         ufp_ready, ufp_rvalid;
    logic [31:0]  ufp_raddr;
    logic [255:0] ufp_rdata;
    logic [31:0]  bmem_addr;
    logic         bmem_read, bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b0;
    logic [31:0]  bmem_raddr = '0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;
`ifdef CACHELINE_ADAPTER_PERF_EN
    logic [31:0]  perf_rd_lines, perf_wr_lines, perf_stall_cycles;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cacheline_mem_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .ufp_addr    (ufp_addr),
        .ufp_read    (ufp_read),
        .ufp_write   (ufp_write),
        .ufp_wdata   (ufp_wdata),
        .ufp_ready   (ufp_ready),
        .ufp_raddr   (ufp_raddr),
        .ufp_rdata   (ufp_rdata),
        .ufp_rvalid  (ufp_rvalid),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
`ifdef CACHELINE_ADAPTER_PERF_EN
        ,
        .perf_rd_lines     (perf_rd_lines),
        .perf_wr_lines     (perf_wr_lines),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    // outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_line(input logic [31:0] a, input logic [31:0] exp_a,
                           input logic [255:0] line, input int req_stall, input bit bad_beat);
        chk("rd_idle_ready", ufp_ready, 1'b1);
        ufp_addr = a; ufp_read = 1'b1; bmem_ready = 1'b1;
        tick();
        ufp_read = 1'b0;
        chk("rd_bmem_read", bmem_read, 1'b1);
        chk("rd_bmem_addr", bmem_addr, exp_a);
        chk("rd_req_not_ready", ufp_ready, 1'b0);
        for (int i = 0; i < req_stall; i++) begin
            bmem_ready = 1'b0;
            tick();
            chk("rd_req_held", bmem_read, 1'b1);
        end
        bmem_ready = 1'b1;
        tick();
        chk("rd_wait_no_req", bmem_read, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rd_wait_not_ready", ufp_ready, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            if (bad_beat && k == 2) begin
                bmem_rvalid = 1'b1; bmem_raddr = exp_a ^ 32'h100; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                tick();
                chk("rd_bad_beat_no_resp", ufp_rvalid, 1'b0);
            end
            bmem_rvalid = 1'b1; bmem_raddr = exp_a; bmem_rdata = line[k*64 +: 64];
            tick();
        end
        bmem_rvalid = 1'b0;
        chk("rd_rvalid", ufp_rvalid, 1'b1);
        chk("rd_raddr", ufp_raddr, exp_a);
        chk("rd_rdata", ufp_rdata, line);
        chk("rd_resp_not_ready", ufp_ready, 1'b0);
        tick();
        chk("rd_rvalid_pulse", ufp_rvalid, 1'b0);
        chk("rd_ready_after", ufp_ready, 1'b1);
    endtask

    task automatic wr_line(input logic [31:0] a, input logic [31:0] exp_a,
                           input logic [255:0] line, input int stall_beat);
        chk("wr_idle_ready", ufp_ready, 1'b1);
        ufp_addr = a; ufp_write = 1'b1; ufp_wdata = line; bmem_ready = 1'b1;
        tick();
        ufp_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == stall_beat) begin
                bmem_ready = 1'b0;
                chk("wr_stall_write", bmem_write, 1'b1);
                chk("wr_stall_data", bmem_wdata, line[k*64 +: 64]);
                tick();
                bmem_ready = 1'b1;
            end
            chk("wr_write", bmem_write, 1'b1);
            chk("wr_addr", bmem_addr, exp_a);
            chk("wr_data", bmem_wdata, line[k*64 +: 64]);
            tick();
        end
        chk("wr_done_write", bmem_write, 1'b0);
        chk("wr_done_ready", ufp_ready, 1'b1);
        chk("wr_no_rvalid", ufp_rvalid, 1'b0);
    endtask

    logic [255:0] line_a = {64'hAAAA_0003_1111_2222, 64'hAAAA_0002_3333_4444,
                            64'hAAAA_0001_5555_6666, 64'hAAAA_0000_7777_8888};
    logic [255:0] line_d = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                            64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
    logic [255:0] line_e = {64'hE3E3_0000_0000_00E3, 64'hE2E2_0000_0000_00E2,
                            64'hE1E1_0000_0000_00E1, 64'hE0E0_0000_0000_00E0};
    logic [255:0] line_x = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
                            64'h0101_0101_0101_0101, 64'h0000_0000_0000_0001};
    logic [7:0] stall_rdy = 8'b1100_1001;  // bit i = bmem_ready on cycle i
    int         stall_idx[8] = '{0, 1, 1, 1, 2, 2, 2, 3};

    initial begin
        // reset state
        tick();
        chk("rst_ready", ufp_ready, 1'b0);
        chk("rst_rvalid", ufp_rvalid, 1'b0);
        chk("rst_bmem_read", bmem_read, 1'b0);
        chk("rst_bmem_write", bmem_write, 1'b0);
        chk("rst_rdata", ufp_rdata, 256'h0);
        chk("rst_addr", bmem_addr, 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", ufp_ready, 1'b1);

        // plain read, unaligned address
        rd_line(32'h1000_0024, 32'h1000_0020, line_a, 0, 1'b0);

        // plain write, no stalls
        wr_line(32'h2000_0047, 32'h2000_0040, line_d, -1);

        // write with two-cycle stalls on beats 1 and 2: 8 cycles total
        ufp_addr = 32'h2000_0080; ufp_write = 1'b1; ufp_wdata = line_e; bmem_ready = 1'b1;
        tick();
        ufp_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bmem_ready = stall_rdy[i];
            chk("stall_write", bmem_write, 1'b1);
            chk("stall_data", bmem_wdata, line_e[stall_idx[i]*64 +: 64]);
            tick();
        end
        bmem_ready = 1'b1;
        chk("stall_done_write", bmem_write, 1'b0);
        chk("stall_done_ready", ufp_ready, 1'b1);

        // stray beat in IDLE, then a read with one mis-tagged beat
        bmem_rvalid = 1'b1; bmem_raddr = 32'h4000_0000; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        bmem_rvalid = 1'b0;
        chk("stray_no_rvalid", ufp_rvalid, 1'b0);
        chk("stray_ready", ufp_ready, 1'b1);
        rd_line(32'h4000_0000, 32'h4000_0000, line_x, 0, 1'b1);

        // reset after two beats abandons the read
        ufp_addr = 32'h3000_0000; ufp_read = 1'b1; bmem_ready = 1'b1;
        tick();
        ufp_read = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h3000_0000; bmem_rdata = line_a[k*64 +: 64];
            tick();
        end
        rst = 1'b1;
        bmem_rdata = line_a[128 +: 64];
        tick();
        chk("mid_rst_rdata", ufp_rdata, 256'h0);
        chk("mid_rst_raddr", ufp_raddr, 32'h0);
        chk("mid_rst_bmem_addr", bmem_addr, 32'h0);
        chk("mid_rst_bmem_read", bmem_read, 1'b0);
        chk("mid_rst_ready", ufp_ready, 1'b0);
        rst = 1'b0;
        bmem_rdata = line_a[192 +: 64];
        tick();
        bmem_rvalid = 1'b0;
        chk("late_beat_no_rvalid", ufp_rvalid, 1'b0);
        chk("late_beat_rdata", ufp_rdata, 256'h0);
        rd_line(32'h3000_003F, 32'h3000_0020, line_e, 1, 1'b0);

`ifdef CACHELINE_ADAPTER_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("perf_rst_rd", perf_rd_lines, 32'd0);
        chk("perf_rst_stall", perf_stall_cycles, 32'd0);
        rd_line(32'h5000_0000, 32'h5000_0000, line_a, 1, 1'b0);
        rd_line(32'h5000_0020, 32'h5000_0020, line_x, 1, 1'b0);
        wr_line(32'h5000_0040, 32'h5000_0040, line_d, 2);
        chk("perf_rd_lines", perf_rd_lines, 32'd2);
        chk("perf_wr_lines", perf_wr_lines, 32'd1);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
